axis_rx_pkt_fifo: RTL and testbench

Store-and-forward packet FIFO between the 512-bit Ethernet MAC RX stream and the user logic `S0_AXIS`/`S1_AXIS` slave inputs, one instance per port. It accepts MAC beats without backpressure and holds each frame until its last beat. Frames flagged bad by MAC `tuser`, or frames that overflow the buffer, are discarded. Only complete, good frames are presented downstream on a `tuser`-less AXI4-Stream master.

---
 rtl/rx_fifo_pkg.sv | 19 +
 rtl/sdp_ram.sv | 31 +++
 rtl/axis_rx_pkt_fifo.sv | 206 ++++++++++++++++++++
 tb/tb_axis_rx_pkt_fifo.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_fifo_pkg.sv
// Shared definitions for the RX store-and-forward packet FIFO:
// default stream widths, write-side FSM states and pointer sizing.
package rx_fifo_pkg;

    localparam int DATA_W_DEF = 512;
    localparam int KEEP_W_DEF = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } wr_state_t;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// No reset on the storage or the read register so it maps onto block/ultra RAM.
module sdp_ram
    import rx_fifo_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF + KEEP_W_DEF + 1,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk) begin
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/axis_rx_pkt_fifo.sv
// Store-and-forward packet FIFO between the MAC RX stream and user logic.
// Frames are held until their last beat; tuser-errored or overflowing frames
// are rewound away, only complete good frames are presented downstream.
// Optional statistics counters: define RX_FIFO_STATS_EN to implement them,
// otherwise the three counter outputs are tied to zero.
module axis_rx_pkt_fifo
    import rx_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int KEEP_W = KEEP_W_DEF,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [31:0]       good_pkt_cnt,
    output logic [31:0]       err_drop_cnt,
    output logic [31:0]       ovf_drop_cnt
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam int BW = DATA_W + KEEP_W + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic          r_tready;
    wr_state_t     r_state;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_cm_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_rd_vld;
    logic [BW-1:0] r_sk_mem [2];
    logic          r_sk_wr;
    logic          r_sk_rd;
    logic [1:0]    r_sk_cnt;

    logic          w_accept;
    logic          w_full;
    logic          w_wr_en;
    logic          w_pkt_avail;
    logic          w_rd_en;
    logic [BW-1:0] w_wdata;
    logic [BW-1:0] w_rdata;
    logic [BW-1:0] w_head;
    logic          w_m_valid;
    logic          w_pop;
    logic          w_sk_push;
    logic          w_sk_pop;

`ifdef RX_FIFO_STATS_EN
    logic [31:0]   r_good_cnt;
    logic [31:0]   r_err_cnt;
    logic [31:0]   r_ovf_cnt;
`endif

    assign w_accept    = s_axis_tvalid & r_tready;
    assign w_full      = (r_wr_ptr - r_rd_ptr) == DEPTH_P;
    assign w_wr_en     = w_accept && (r_state != DROP) && !w_full;
    assign w_wdata     = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    assign w_pkt_avail = r_rd_ptr != r_cm_ptr;
    // A read is only issued if the beat it returns is sure to find a skid slot.
    assign w_rd_en     = w_pkt_avail && ((r_sk_cnt + {1'b0, r_rd_vld}) <= 2'd1);

    // The MAC is never stalled; ready simply comes up one edge after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_tready <= 1'b0;
        else          r_tready <= 1'b1;
    end

    // Write FSM: speculative write, commit on good tlast, rewind on error/overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_cm_ptr <= '0;
`ifdef RX_FIFO_STATS_EN
            r_good_cnt <= '0;
            r_err_cnt  <= '0;
            r_ovf_cnt  <= '0;
`endif
        end else if (w_accept) begin
            case (r_state)
                IDLE, PKT: begin
                    if (w_full) begin
                        r_wr_ptr <= r_cm_ptr;
                        if (s_axis_tlast) begin
                            r_state <= IDLE;
`ifdef RX_FIFO_STATS_EN
                            r_ovf_cnt <= r_ovf_cnt + 32'd1;
`endif
                        end else begin
                            r_state <= DROP;
                        end
                    end else if (s_axis_tlast) begin
                        r_state <= IDLE;
                        if (s_axis_tuser) begin
                            r_wr_ptr <= r_cm_ptr;
`ifdef RX_FIFO_STATS_EN
                            r_err_cnt <= r_err_cnt + 32'd1;
`endif
                        end else begin
                            r_wr_ptr <= r_wr_ptr + PTR_ONE;
                            r_cm_ptr <= r_wr_ptr + PTR_ONE;
`ifdef RX_FIFO_STATS_EN
                            r_good_cnt <= r_good_cnt + 32'd1;
`endif
                        end
                    end else begin
                        r_wr_ptr <= r_wr_ptr + PTR_ONE;
                        r_state  <= PKT;
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        r_state <= IDLE;
`ifdef RX_FIFO_STATS_EN
                        r_ovf_cnt <= r_ovf_cnt + 32'd1;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sdp_ram #(
        .WIDTH (BW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_wdata),
        .i_re    (w_rd_en),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    // Read pointer and the flag marking a RAM beat arriving this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_en;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Output queue is the skid entries followed by the RAM beat in flight;
    // the RAM beat bypasses the skid when nothing is queued ahead of it.
    assign w_m_valid = (r_sk_cnt != 2'd0) || r_rd_vld;
    assign w_head    = (r_sk_cnt != 2'd0) ? r_sk_mem[r_sk_rd] : w_rdata;
    assign w_pop     = w_m_valid && m_axis_tready;
    assign w_sk_pop  = w_pop && (r_sk_cnt != 2'd0);
    assign w_sk_push = r_rd_vld && !(w_pop && (r_sk_cnt == 2'd0));

    // Skid FIFO bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sk_cnt <= 2'd0;
            r_sk_wr  <= 1'b0;
            r_sk_rd  <= 1'b0;
        end else begin
            if (w_sk_push) r_sk_wr <= ~r_sk_wr;
            if (w_sk_pop)  r_sk_rd <= ~r_sk_rd;
            case ({w_sk_push, w_sk_pop})
                2'b10:   r_sk_cnt <= r_sk_cnt + 2'd1;
                2'b01:   r_sk_cnt <= r_sk_cnt - 2'd1;
                default: r_sk_cnt <= r_sk_cnt;
            endcase
        end
    end

    // Skid storage, left unreset since the output is masked while empty.
    always_ff @(posedge clk) begin
        if (w_sk_push) r_sk_mem[r_sk_wr] <= w_rdata;
    end

    assign s_axis_tready = r_tready;
    assign m_axis_tvalid = w_m_valid;
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = w_m_valid ? w_head : '0;

`ifdef RX_FIFO_STATS_EN
    assign good_pkt_cnt = r_good_cnt;
    assign err_drop_cnt = r_err_cnt;
    assign ovf_drop_cnt = r_ovf_cnt;
`else
    assign good_pkt_cnt = 32'd0;
    assign err_drop_cnt = 32'd0;
    assign ovf_drop_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_axis_rx_pkt_fifo.sv
// Directed bench for axis_rx_pkt_fifo (DEPTH=16). Counter expectations follow
// the RX_FIFO_STATS_EN build macro: real counts when defined, zero otherwise.
module tb_axis_rx_pkt_fifo;

    localparam int DATA_W = 512;
    localparam int KEEP_W = 64;
    localparam int DEPTH  = 16;
    localparam int BW     = DATA_W + KEEP_W + 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] s_axis_tdata;
    logic [KEEP_W-1:0] s_axis_tkeep;
    logic              s_axis_tlast;
    logic              s_axis_tuser;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [31:0]       good_pkt_cnt;
    logic [31:0]       err_drop_cnt;
    logic [31:0]       ovf_drop_cnt;

    int                nChecks = 0;
    int                nErrors = 0;
    logic [BW-1:0]     expQ[$];
    logic [BW-1:0]     gotQ[$];
    logic              prevStall = 1'b0;
    logic [BW-1:0]     prevBeat = '0;
    logic              stimDone = 1'b0;

    axis_rx_pkt_fifo #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .good_pkt_cnt  (good_pkt_cnt),
        .err_drop_cnt  (err_drop_cnt),
        .ovf_drop_cnt  (ovf_drop_cnt)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    function automatic logic [31:0] expCnt(input logic [31:0] v);
`ifdef RX_FIFO_STATS_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [KEEP_W-1:0] lastKeep(input int fid);
        logic [KEEP_W-1:0] k;
        k = '1;
        return k >> (fid % 64);
    endfunction

    function automatic logic [BW-1:0] mkBeat(input int fid, input int bidx,
                                             input logic last, input logic [KEEP_W-1:0] keep);
        logic [31:0] w;
        w = {fid[15:0], bidx[15:0]};
        return {last, keep, {16{w}}};
    endfunction

    task automatic checkOutput(input string tag, input logic [BW-1:0] observed,
                               input logic [BW-1:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [BW-1:0] beat, input logic user);
        {s_axis_tlast, s_axis_tkeep, s_axis_tdata} = beat;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input int fid, input int len, input logic user,
                             input logic good, input logic zeroFirstKeep);
        logic [KEEP_W-1:0] keep;
        logic [BW-1:0]     beat;
        logic              last;
        for (int b = 0; b < len; b++) begin
            last = (b == len - 1);
            keep = last ? lastKeep(fid) : '1;
            if (zeroFirstKeep && b == 0) keep = '0;
            beat = mkBeat(fid, b, last, keep);
            if (good) expQ.push_back(beat);
            applyStimulus(beat, last && user);
        end
    endtask

    task automatic waitBeats(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while (gotQ.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        checkOutput(tag, BW'(gotQ.size() >= n), BW'(1));
    endtask

    task automatic compareQueues(input string tag);
        int n;
        checkOutput({tag, "_len"}, BW'(gotQ.size()), BW'(expQ.size()));
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < n; i++) checkOutput({tag, "_beat"}, gotQ[i], expQ[i]);
        gotQ.delete();
        expQ.delete();
    endtask

    task automatic checkCounters(input string tag, input logic [31:0] g,
                                 input logic [31:0] e, input logic [31:0] o);
        checkOutput({tag, "_good"}, BW'(good_pkt_cnt), BW'(expCnt(g)));
        checkOutput({tag, "_err"},  BW'(err_drop_cnt), BW'(expCnt(e)));
        checkOutput({tag, "_ovf"},  BW'(ovf_drop_cnt), BW'(expCnt(o)));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_s_tready"}, BW'(s_axis_tready), BW'(0));
        checkOutput({tag, "_m_tvalid"}, BW'(m_axis_tvalid), BW'(0));
        checkOutput({tag, "_m_beat"}, {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, '0);
        checkOutput({tag, "_good"}, BW'(good_pkt_cnt), BW'(0));
        checkOutput({tag, "_err"},  BW'(err_drop_cnt), BW'(0));
        checkOutput({tag, "_ovf"},  BW'(ovf_drop_cnt), BW'(0));
    endtask

    // Output monitor: records handshaken beats and checks stability under stall.
    always @(negedge clk) begin
        if (!reset_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_valid", BW'(m_axis_tvalid), BW'(1));
                checkOutput("stall_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, prevBeat);
            end
            if (m_axis_tvalid && m_axis_tready)
                gotQ.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
            prevStall = m_axis_tvalid && !m_axis_tready;
            prevBeat  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        end
    end

    // Run-away guard.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int len4;
        reset_n       = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        #1 reset_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("rst");
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_tready_before_edge", BW'(s_axis_tready), BW'(0));
        @(posedge clk);
        #1;
        checkOutput("rst_tready_after_edge", BW'(s_axis_tready), BW'(1));

        // Scenario 1: 4-beat good frame, latency of 2 cycles after tlast
        sendFrame(1, 4, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("s1_valid_t1", BW'(m_axis_tvalid), BW'(0));
        @(negedge clk);
        checkOutput("s1_valid_t2", BW'(m_axis_tvalid), BW'(1));
        waitBeats("s1_wait", 4, 50);
        idle(5);
        compareQueues("s1");
        checkCounters("s1", 32'd1, 32'd0, 32'd0);

        // Scenario 2: errored 3-beat frame then 2-beat good frame (zero tkeep beat)
        sendFrame(2, 3, 1'b1, 1'b0, 1'b0);
        sendFrame(3, 2, 1'b0, 1'b1, 1'b1);
        waitBeats("s2_wait", 2, 50);
        idle(10);
        compareQueues("s2");
        checkCounters("s2", 32'd2, 32'd1, 32'd0);

        // Scenario 3: 20-beat frame overflows the 16-deep buffer, 1-beat frame kept
        m_axis_tready = 1'b0;
        sendFrame(4, 20, 1'b0, 1'b0, 1'b0);
        sendFrame(5, 1, 1'b0, 1'b1, 1'b0);
        idle(10);
        checkCounters("s3", 32'd3, 32'd1, 32'd1);
        checkOutput("s3_held", BW'(gotQ.size()), BW'(0));
        m_axis_tready = 1'b1;
        waitBeats("s3_wait", 1, 50);
        idle(10);
        compareQueues("s3");

        // Scenario 3b: a frame of exactly DEPTH beats fits and is committed
        m_axis_tready = 1'b0;
        sendFrame(6, DEPTH, 1'b0, 1'b1, 1'b0);
        idle(10);
        m_axis_tready = 1'b1;
        waitBeats("s3b_wait", DEPTH, 100);
        idle(5);
        compareQueues("s3b");
        checkCounters("s3b", 32'd4, 32'd1, 32'd1);

        // Scenario 4: 100 frames of 1..8 beats under random output backpressure
        fork
            begin
                for (int f = 0; f < 100; f++) begin
                    len4 = $urandom_range(1, 8);
                    sendFrame(100 + f, len4, 1'b0, 1'b1, 1'b0);
                    idle(4 * len4 + 8);
                end
                stimDone = 1'b1;
            end
            begin
                while (!stimDone) begin
                    @(posedge clk);
                    #1;
                    m_axis_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_axis_tready = 1'b1;
        waitBeats("s4_wait", expQ.size(), 500);
        idle(10);
        compareQueues("s4");
        checkCounters("s4", 32'd104, 32'd1, 32'd1);

        // Scenario 5: reset mid-frame with a committed, unread frame
        m_axis_tready = 1'b0;
        sendFrame(300, 2, 1'b0, 1'b1, 1'b0);
        idle(4);
        checkOutput("s5_pre_valid", BW'(m_axis_tvalid), BW'(1));
        applyStimulus(mkBeat(301, 0, 1'b0, '1), 1'b0);
        applyStimulus(mkBeat(301, 1, 1'b0, '1), 1'b0);
        reset_n = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkResetOutputs("s5_rst");
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1 m_axis_tready = 1'b1;
        idle(10);
        checkOutput("s5_no_stale", BW'(gotQ.size()), BW'(0));
        gotQ.delete();
        sendFrame(302, 3, 1'b0, 1'b1, 1'b0);
        waitBeats("s5_wait", 3, 50);
        idle(5);
        compareQueues("s5");
        checkCounters("s5", 32'd1, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
